// File: rtl/decode_stage.sv
// Decode stage: splits the instruction, reads a bypassed register file, tracks
// pending destinations in a busy scoreboard and hands operands to execute.
module decode_stage #(
    parameter int LEN_INSN    = 32,
    parameter int LEN_OPECODE = 7,
    parameter int LEN_IMMF    = 1,
    parameter int LEN_REG     = 32,
    parameter int LEN_CC      = 4,
    parameter int LEN_IMM_EX  = 32,
    parameter int NREG        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [LEN_INSN-1:0]    insn,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LEN_OPECODE-1:0] opecode,
    output logic [LEN_IMMF-1:0]    immf,
    output logic [LEN_REG-1:0]     data_rd,
    output logic [LEN_REG-1:0]     data_rs,
    output logic [LEN_CC-1:0]      cc,
    output logic [LEN_IMM_EX-1:0]  imm_ex,
    output logic [3:0]             rd_addr,
    input  logic                   wb_en,
    input  logic [3:0]             wb_addr,
    input  logic [LEN_REG-1:0]     wb_data,
    output logic                   halted
);

    localparam logic [6:0] OP_CMP = 7'b0000100;
    localparam logic [6:0] OP_LD  = 7'b0011000;
    localparam logic [6:0] OP_HLT = 7'b1111111;

    logic [6:0]            dec_op;
    logic                  dec_immf;
    logic [3:0]            dec_rd;
    logic [3:0]            dec_rs;
    logic [3:0]            dec_cc;
    logic [15:0]           dec_imm;
    logic [LEN_IMM_EX-1:0] dec_imm_ex;
    logic                  dec_logic_grp;
    logic                  dec_writes_rd;

    logic [LEN_REG-1:0] regs [NREG];
    logic [LEN_REG-1:0] rd_val;
    logic [LEN_REG-1:0] rs_val;

    logic [15:0] busy;
    logic [15:0] busy_next;
    logic        hazard;
    logic        issue;

    assign dec_op   = insn[31:25];
    assign dec_immf = insn[24];
    assign dec_rd   = insn[23:20];
    assign dec_rs   = insn[19:16];
    assign dec_cc   = insn[15:12];
    assign dec_imm  = insn[15:0];

    assign dec_logic_grp = (dec_op[6:3] == 4'b0010);

    always_comb begin
        dec_imm_ex = '0;
        if (dec_logic_grp) begin
            dec_imm_ex = {{(LEN_IMM_EX-16){1'b0}}, dec_imm};
        end else begin
            dec_imm_ex = {{(LEN_IMM_EX-16){dec_imm[15]}}, dec_imm};
        end
    end

    assign dec_writes_rd = ((dec_op[6:4] == 3'b000) && (dec_op != OP_CMP))
                         || dec_logic_grp
                         || (dec_op == OP_LD);

    // Same-cycle writeback is forwarded so the captured operand is never stale.
    always_comb begin
        rd_val = regs[dec_rd];
        rs_val = regs[dec_rs];
        if (wb_en && (wb_addr == dec_rd)) begin
            rd_val = wb_data;
        end
        if (wb_en && (wb_addr == dec_rs)) begin
            rs_val = wb_data;
        end
    end

    assign hazard   = busy[dec_rs] | busy[dec_rd];
    assign in_ready = !halted && !hazard && (!out_valid || out_ready);
    assign issue    = in_valid && in_ready;

    // Clear first, then set, so a same-index issue keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (wb_en) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (issue && dec_writes_rd) begin
            busy_next[dec_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (issue && (dec_op == OP_HLT)) begin
            halted <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            opecode   <= '0;
            immf      <= '0;
            data_rd   <= '0;
            data_rs   <= '0;
            cc        <= '0;
            imm_ex    <= '0;
            rd_addr   <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            opecode   <= dec_op;
            immf      <= dec_immf;
            data_rd   <= rd_val;
            data_rs   <= rs_val;
            cc        <= dec_cc;
            imm_ex    <= dec_imm_ex;
            rd_addr   <= dec_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomised bench for decode_stage: a cycle-level reference model predicts
// handshakes and pushes expected outputs to a queue checked by a monitor.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] insn = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  opecode;
    logic [0:0]  immf;
    logic [31:0] data_rd;
    logic [31:0] data_rs;
    logic [3:0]  cc;
    logic [31:0] imm_ex;
    logic [3:0]  rd_addr;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        halted;

    decode_stage #(
        .LEN_INSN(32), .LEN_OPECODE(7), .LEN_IMMF(1), .LEN_REG(32),
        .LEN_CC(4), .LEN_IMM_EX(32), .NREG(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .insn(insn),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .opecode(opecode), .immf(immf), .data_rd(data_rd), .data_rs(data_rs),
        .cc(cc), .imm_ex(imm_ex), .rd_addr(rd_addr), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  op;
        logic        immf;
        logic [31:0] drd;
        logic [31:0] drs;
        logic [3:0]  cc;
        logic [31:0] imm;
        logic [3:0]  rda;
    } rec_t;

    rec_t q[$];

    int tests = 0;
    int fails = 0;

    logic [31:0] m_regs [16];
    bit          m_busy [16];
    bit          m_halted;
    bit          m_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit writes_rd(input logic [6:0] op);
        int o;
        o = int'(op);
        return ((o <= 7) && (o != 4)) || ((o >= 16) && (o <= 23)) || (o == 24);
    endfunction

    function automatic logic [31:0] ext_imm(input logic [6:0] op, input logic [15:0] imm);
        int o;
        o = int'(op);
        if ((o >= 16) && (o <= 23)) return {16'h0000, imm};
        return 32'($signed(imm));
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input logic f,
                                       input logic [3:0] rd, input logic [3:0] rs,
                                       input logic [15:0] imm);
        return {op, f, rd, rs, imm};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_halted = 1'b0;
        m_ov = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic [31:0] i, input logic ordy,
                         input logic we, input logic [3:0] wa, input logic [31:0] wd);
        logic [6:0] op;
        logic [3:0] rdi, rsi;
        bit exp_ready, iss;
        rec_t r;
        @(negedge clk);
        in_valid = v; insn = i; out_ready = ordy;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        op = i[31:25]; rdi = i[23:20]; rsi = i[19:16];
        exp_ready = !m_halted && !m_busy[rsi] && !m_busy[rdi] && (!m_ov || ordy);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        iss = v && exp_ready;
        if (iss) begin
            r.op   = op;
            r.immf = i[24];
            r.drd  = (we && wa == rdi) ? wd : m_regs[rdi];
            r.drs  = (we && wa == rsi) ? wd : m_regs[rsi];
            r.cc   = i[15:12];
            r.imm  = ext_imm(op, i[15:0]);
            r.rda  = rdi;
            q.push_back(r);
        end
        if (we) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (iss && writes_rd(op)) m_busy[rdi] = 1'b1;
        if (iss && op == 7'h7f) m_halted = 1'b1;
        if (iss) m_ov = 1'b1;
        else if (ordy) m_ov = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1;
        wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'hDEAD_BEEF;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        q.delete();
        model_clear();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    // Monitor: compares the presented output against the queue head every
    // valid cycle (covers holding under back-pressure) and pops on consume.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_unexpected: got out_valid=1 expected no pending insn at %0t", $time);
                end else begin
                    r = q[0];
                    chk("opecode", {25'b0, opecode}, {25'b0, r.op});
                    chk("immf", {31'b0, immf}, {31'b0, r.immf});
                    chk("data_rd", data_rd, r.drd);
                    chk("data_rs", data_rs, r.drs);
                    chk("cc", {28'b0, cc}, {28'b0, r.cc});
                    chk("imm_ex", imm_ex, r.imm);
                    chk("rd_addr", {28'b0, rd_addr}, {28'b0, r.rda});
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    function automatic logic [3:0] pick_wb();
        logic [3:0] cand [$];
        for (int i = 0; i < 16; i++) if (m_busy[i]) cand.push_back(4'(i));
        if (cand.size() != 0 && $urandom_range(0, 3) != 0)
            return cand[$urandom_range(0, cand.size() - 1)];
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 7'h00;
            1: return 7'h04;
            2: return 7'($urandom_range(0, 7));
            3: return 7'($urandom_range(16, 23));
            4: return 7'h18;
            default: return 7'($urandom_range(25, 126));
        endcase
    endfunction

    initial begin
        model_clear();
        do_reset();

        // add rd=1 rs=2 imm=0xFFFF
        cycle(1, 32'h0012_FFFF, 1, 0, 4'd0, 32'd0);
        // reads r1 -> stalls on busy[1], then clear it
        cycle(1, mk(7'h04, 0, 4'd6, 4'd1, 16'h0), 1, 0, 4'd0, 32'd0);
        cycle(1, mk(7'h04, 0, 4'd6, 4'd1, 16'h0), 1, 1, 4'd1, 32'hCAFE_0001);
        cycle(1, mk(7'h04, 0, 4'd6, 4'd1, 16'h0), 1, 0, 4'd0, 32'd0);
        // logic group zero-extends
        cycle(1, mk(7'h10, 1, 4'd4, 4'd6, 16'h8000), 1, 0, 4'd0, 32'd0);
        cycle(0, 32'd0, 1, 1, 4'd4, 32'h0000_0044);

        // RAW hazard on r3, resolved by writeback of 0x1234
        cycle(1, mk(7'h00, 0, 4'd3, 4'd7, 16'h0010), 1, 0, 4'd0, 32'd0);
        for (int k = 0; k < 3; k++) cycle(1, mk(7'h04, 0, 4'd8, 4'd3, 16'h0), 1, 0, 4'd0, 32'd0);
        cycle(1, mk(7'h04, 0, 4'd8, 4'd3, 16'h0), 1, 1, 4'd3, 32'h0000_1234);
        cycle(1, mk(7'h04, 0, 4'd8, 4'd3, 16'h0), 1, 0, 4'd0, 32'd0);

        // back-pressure: hold 3 cycles, then queued insn issues
        cycle(1, mk(7'h04, 0, 4'd9, 4'd10, 16'h1111), 1, 0, 4'd0, 32'd0);
        for (int k = 0; k < 3; k++) cycle(1, mk(7'h04, 1, 4'd11, 4'd12, 16'h2222), 0, 0, 4'd0, 32'd0);
        cycle(1, mk(7'h04, 1, 4'd11, 4'd12, 16'h2222), 1, 0, 4'd0, 32'd0);

        // same-index issue and writeback: set wins, r5 takes wb_data
        cycle(1, mk(7'h00, 0, 4'd5, 4'd13, 16'h0001), 1, 1, 4'd5, 32'h5555_AAAA);
        cycle(1, mk(7'h04, 0, 4'd14, 4'd5, 16'h0), 1, 0, 4'd0, 32'd0);
        cycle(1, mk(7'h04, 0, 4'd14, 4'd5, 16'h0), 1, 1, 4'd5, 32'h5555_AAAA);
        cycle(1, mk(7'h04, 0, 4'd14, 4'd5, 16'h0), 1, 0, 4'd0, 32'd0);

        for (int n = 0; n < 800; n++) begin
            logic [6:0] op;
            op = pick_op();
            cycle(1'($urandom_range(0, 3) != 0),
                  mk(op, 1'($urandom), 4'($urandom), 4'($urandom), 16'($urandom)),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), pick_wb(), $urandom);
        end

        // drain scoreboard so the hlt can issue
        for (int k = 0; k < 16; k++) cycle(0, 32'd0, 1, 1, 4'(k), 32'(k * 3));
        cycle(1, mk(7'h7f, 0, 4'd2, 4'd3, 16'h0F0F), 1, 0, 4'd0, 32'd0);
        for (int k = 0; k < 4; k++) cycle(1, mk(7'h04, 0, 4'd6, 4'd7, 16'h0), k == 3, 0, 4'd0, 32'd0);
        cycle(1, mk(7'h04, 0, 4'd6, 4'd7, 16'h0), 1, 0, 4'd0, 32'd0);

        // hlt with output held, then reset mid-stream
        do_reset();
        cycle(1, mk(7'h7f, 0, 4'd1, 4'd2, 16'h0), 0, 0, 4'd0, 32'd0);
        cycle(1, mk(7'h04, 0, 4'd3, 4'd4, 16'h0), 0, 0, 4'd0, 32'd0);
        do_reset();
        for (int k = 0; k < 16; k += 2) cycle(1, mk(7'h04, 0, 4'(k), 4'(k + 1), 16'h0), 1, 0, 4'd0, 32'd0);
        for (int k = 0; k < 3; k++) cycle(0, 32'd0, 1, 0, 4'd0, 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameters: LEN_INSN 32 instruction width; LEN_OPECODE 7; LEN_IMMF 1; LEN_REG 32 register data width; LEN_CC 4; LEN_IMM_EX 32 extended-immediate width; NREG 16 register count.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  insn is valid
- insn  in  LEN_INSN  fetched instruction
- in_ready  out  1  decode accepts insn this cycle
- out_valid  out  1  decoded operands valid for execute
- out_ready  in  1  execute consumes this cycle
- opecode  out  LEN_OPECODE  to execute
- immf  out  LEN_IMMF  to execute
- data_rd  out  LEN_REG  rd operand
- data_rs  out  LEN_REG  rs operand
- cc  out  LEN_CC  condition code
- imm_ex  out  LEN_IMM_EX  extended immediate
- rd_addr  out  4  destination index, for writeback
- wb_en  in  1  writeback strobe
- wb_addr  in  4  writeback index
- wb_data  in  LEN_REG  writeback value
- halted  out  1  hlt decoded, sticky

Function
REQ-003 SHALL split insn as: opecode=[31:25], immf=[24], rd=[23:20], rs=[19:16], cc=[15:12], imm=[15:0].
REQ-004 SHALL zero-extend imm into imm_ex when opecode[6:3]==4'b0010 (logic group), and sign-extend it otherwise.
REQ-005 SHALL hold an NREG x LEN_REG register file, written on the clk edge when wb_en=1.
REQ-006 SHALL bypass register reads: if wb_en=1 and wb_addr equals rd or rs in the issue cycle, the captured operand is wb_data.
REQ-007 SHALL classify an insn as writes-rd when any of the following holds:
- opecode[6:4]==3'b000 and opecode!=7'b0000100 (cmp excluded)
- opecode[6:3]==4'b0010
- opecode==7'b0011000 (ld)
REQ-008 SHALL keep a 16-bit busy scoreboard:
- set bit rd on issue of a writes-rd insn
- clear bit wb_addr on wb_en
- when issue and writeback hit the same index in one cycle, set wins.
REQ-009 SHALL detect a hazard when busy[rs] or busy[rd] is 1 in the current cycle, evaluated before that cycle's clear takes effect.
REQ-010 SHALL drive in_ready = !halted && !hazard && (!out_valid || out_ready).
REQ-011 SHALL issue when in_valid && in_ready; on issue it captures all decoded fields and operands into the output registers and sets out_valid=1 on the next edge.
REQ-012 SHALL clear out_valid when out_ready=1 and no issue occurs in that cycle.
REQ-013 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-014 SHALL treat opecode 7'b1111111 (hlt) as follows on issue:
- set halted=1, which persists until rst
- forward the insn to execute like any other
- accept no further insns.
REQ-015 SHALL provide one-cycle latency from issue to out_valid, with throughput of one insn per cycle when there are no hazards.
REQ-016 SHALL keep the captured operands unchanged when a later writeback hits a register already captured (no retroactive update).

Reset
REQ-017 SHALL, on rst=1 and independent of clk, clear out_valid, halted, the busy scoreboard, every register file entry, and all output data registers to 0.
REQ-018 SHALL leave in_ready=1 immediately after rst deasserts.
REQ-019 SHALL discard any in-flight decoded insn when rst asserts mid-operation, and SHALL ignore any writeback that occurs during rst.

Verification
REQ-020 Reset then insn 0x0012_FFFF (add, rd=1, rs=2, imm=0xFFFF), out_ready=1 -> next cycle:
- out_valid=1, opecode=0, rd_addr=1, imm_ex=0xFFFF_FFFF, data_rd=0, data_rs=0
- busy[1]=1.
REQ-021 Insn with opecode 0010000 and imm=0x8000 -> imm_ex=0x0000_8000.
REQ-022 Issue add rd=3, then an insn reading rs=3 with no writeback -> in_ready=0 every cycle; then wb_en=1, wb_addr=3, wb_data=0x1234 -> insn issues next edge with data_rs=0x1234.
REQ-023 out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0 and outputs unchanged; out_ready=1 -> next queued insn issues in the same cycle.
REQ-024 Simultaneous wb_en to r5 and issue of a writes-rd insn with rd=5 -> busy[5]=1 afterwards, and r5 holds wb_data.
REQ-025 Issue hlt -> halted=1 and in_ready=0 indefinitely; assert rst mid-stream -> out_valid=0, halted=0, and all registers read 0.
